// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU issue stage.
//   XLEN           datapath width of operands/results
//   REG_AW         register index width (index 0 reads as zero)
//   alu_op_e       3-bit ALU opcode
//   stage_state_e  occupancy state of the ID/EX register
package alu_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MUL = 3'b010,
    ALU_DIV = 3'b011
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_BUBBLE = 2'd2
  } stage_state_e;
endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of every non-clock signal of the issue stage.
//   master : decode / forwarding sources / ALU side (drives requests, out_ready)
//   slave  : the issue stage itself
interface alu_issue_stage_if;
  import alu_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  alu_op_e           in_opcode;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [REG_AW-1:0] in_rd;
  logic [XLEN-1:0]   in_rs1_data;
  logic [XLEN-1:0]   in_rs2_data;
  logic [XLEN-1:0]   in_imm;
  logic              in_use_imm;
  logic              in_is_load;
  logic              exmem_valid;
  logic [REG_AW-1:0] exmem_rd;
  logic [XLEN-1:0]   exmem_result;
  logic              memwb_valid;
  logic [REG_AW-1:0] memwb_rd;
  logic [XLEN-1:0]   memwb_result;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   operandA;
  logic [XLEN-1:0]   operandB;
  alu_op_e           opcode;
  logic [REG_AW-1:0] out_rd;
  logic              out_is_load;
  logic              out_div_zero;

  modport master (
    output flush, in_valid, in_opcode, in_rs1, in_rs2, in_rd, in_rs1_data,
           in_rs2_data, in_imm, in_use_imm, in_is_load, exmem_valid, exmem_rd,
           exmem_result, memwb_valid, memwb_rd, memwb_result, out_ready,
    input  in_ready, out_valid, operandA, operandB, opcode, out_rd,
           out_is_load, out_div_zero
  );

  modport slave (
    input  flush, in_valid, in_opcode, in_rs1, in_rs2, in_rd, in_rs1_data,
           in_rs2_data, in_imm, in_use_imm, in_is_load, exmem_valid, exmem_rd,
           exmem_result, memwb_valid, memwb_rd, memwb_result, out_ready,
    output in_ready, out_valid, operandA, operandB, opcode, out_rd,
           out_is_load, out_div_zero
  );
endinterface

// File: rtl/operand_fwd_mux.sv
// Operand bypass selector for one source register.
//   rs_i                      source index (0 always yields 0)
//   reg_data_i                value held in the stage register
//   exmem_valid_i/_rd_i/_result_i  youngest producer (highest priority)
//   memwb_valid_i/_rd_i/_result_i  older producer
//   value_o                   resolved operand
module operand_fwd_mux
  import alu_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic [XLEN-1:0]   reg_data_i,
  input  logic              exmem_valid_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]   exmem_result_i,
  input  logic              memwb_valid_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]   memwb_result_i,
  output logic [XLEN-1:0]   value_o
);

  // A match against rs_i != 0 implies the producer rd is also non-zero.
  always_comb begin
    value_o = reg_data_i;
    if (rs_i == '0) begin
      value_o = '0;
    end else if (exmem_valid_i && (exmem_rd_i == rs_i)) begin
      value_o = exmem_result_i;
    end else if (memwb_valid_i && (memwb_rd_i == rs_i)) begin
      value_o = memwb_result_i;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register in front of the ALU: holds one decoded instruction,
// bypasses operands from EX/MEM and MEM/WB, inserts a one-cycle load-use
// bubble and flags divide-by-zero at issue.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_issue_stage_if.slave (decode in, forwarding in, ALU out)
//
//   state     | meaning
//   ST_EMPTY  | nothing held, out_valid low
//   ST_FULL   | instruction held and offered to the ALU
//   ST_BUBBLE | load-use gap: load just left, dependent may be accepted now
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_issue_stage_if.slave  bus
);

  stage_state_e      state_q, state_d;
  alu_op_e           opcode_q;
  logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
  logic              is_load_q, use_imm_q;
  logic [XLEN-1:0]   opa_q, opb_q;

  logic              out_valid, in_ready, hazard;
  logic              load_en, refresh_en;
  logic [XLEN-1:0]   fwd_a, fwd_b, operand_b;

  // The held load's result is not yet available to anything reading it now.
  assign hazard = (state_q == ST_FULL) && is_load_q && (rd_q != '0) &&
                  ((rd_q == bus.in_rs1) || (!bus.in_use_imm && (rd_q == bus.in_rs2)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY, ST_BUBBLE: state_d = bus.in_valid ? ST_FULL : ST_EMPTY;
        ST_FULL: begin
          if (bus.out_ready) begin
            if (hazard)            state_d = ST_BUBBLE;
            else if (bus.in_valid) state_d = ST_FULL;
            else                   state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == ST_FULL);
    in_ready  = !hazard && (!out_valid || bus.out_ready);
  end

  assign load_en    = bus.in_valid && in_ready && !bus.flush;
  // While stalled, capture the bypassed values so they survive the producer
  // leaving the pipeline.
  assign refresh_en = out_valid && !bus.out_ready && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q  <= ALU_ADD;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      is_load_q <= 1'b0;
      use_imm_q <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
    end else if (load_en) begin
      opcode_q  <= bus.in_opcode;
      rd_q      <= bus.in_rd;
      rs1_q     <= bus.in_rs1;
      rs2_q     <= bus.in_rs2;
      is_load_q <= bus.in_is_load;
      use_imm_q <= bus.in_use_imm;
      opa_q     <= bus.in_rs1_data;
      opb_q     <= bus.in_use_imm ? bus.in_imm : bus.in_rs2_data;
    end else if (refresh_en) begin
      opa_q <= fwd_a;
      opb_q <= operand_b;
    end
  end

  operand_fwd_mux u_fwd_a (
    .rs_i          (rs1_q),
    .reg_data_i    (opa_q),
    .exmem_valid_i (bus.exmem_valid),
    .exmem_rd_i    (bus.exmem_rd),
    .exmem_result_i(bus.exmem_result),
    .memwb_valid_i (bus.memwb_valid),
    .memwb_rd_i    (bus.memwb_rd),
    .memwb_result_i(bus.memwb_result),
    .value_o       (fwd_a)
  );

  operand_fwd_mux u_fwd_b (
    .rs_i          (rs2_q),
    .reg_data_i    (opb_q),
    .exmem_valid_i (bus.exmem_valid),
    .exmem_rd_i    (bus.exmem_rd),
    .exmem_result_i(bus.exmem_result),
    .memwb_valid_i (bus.memwb_valid),
    .memwb_rd_i    (bus.memwb_rd),
    .memwb_result_i(bus.memwb_result),
    .value_o       (fwd_b)
  );

  // Immediates bypass the forwarding network entirely.
  assign operand_b = use_imm_q ? opb_q : fwd_b;

  assign bus.out_valid    = out_valid;
  assign bus.in_ready     = in_ready;
  assign bus.operandA     = fwd_a;
  assign bus.operandB     = operand_b;
  assign bus.opcode       = opcode_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_is_load  = is_load_q;
  assign bus.out_div_zero = out_valid && (opcode_q == ALU_DIV) && (operand_b == '0);

endmodule
